// File: rtl/per_pkg.sv
// Shared definitions for the peripheral return-path transmitter.
package per_pkg;

    localparam int DATA_W_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/per_fifo.sv
// Small circular buffer holding words waiting for the CPU handshake.
module per_fifo
    import per_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/periferico_tx.sv
// Drains the local FIFO to the CPU over a 4-phase send/ack handshake.
module periferico_tx
    import per_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              per_clock,
    input  logic              per_reset,
    input  logic              per_wr_en,
    input  logic [DATA_W-1:0] per_wr_data,
    output logic              per_full,
    output logic [CW-1:0]     per_count,
    output logic              per_ovf,
    output logic              per_send,
    input  logic              per_ack,
    output logic [DATA_W-1:0] per_dados
);

    state_t            state_q, state_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] dados_q, dados_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic              empty;
    logic [DATA_W-1:0] head;

    per_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (per_clock),
        .rst_n (per_reset),
        .push  (per_wr_en),
        .pop   (pop),
        .wdata (per_wr_data),
        .rdata (head),
        .count (per_count),
        .full  (per_full),
        .empty (empty)
    );

    // A still-high ack from the previous word blocks the next send.
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        dados_d = dados_q;
        ovf_d   = ovf_q | (per_wr_en & per_full);
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !per_ack) begin
                    dados_d = head;
                    send_d  = 1'b1;
                    pop     = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (per_ack) begin
                    send_d  = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!per_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge per_clock or negedge per_reset) begin
        if (!per_reset) begin
            state_q <= S_IDLE;
            send_q  <= 1'b0;
            dados_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            dados_q <= dados_d;
            ovf_q   <= ovf_d;
        end
    end

    assign per_send  = send_q;
    assign per_dados = dados_q;
    assign per_ovf   = ovf_q;

endmodule

// File: tb/tb_periferico_tx.sv
// Directed self-checking bench for periferico_tx.
module tb_periferico_tx;

    logic       per_clock = 1'b0;
    logic       per_reset = 1'b1;
    logic       per_wr_en = 1'b0;
    logic [3:0] per_wr_data = '0;
    logic       per_full;
    logic [2:0] per_count;
    logic       per_ovf;
    logic       per_send;
    logic       per_ack = 1'b0;
    logic [3:0] per_dados;

    int n_pass = 0;
    int n_total = 0;

    periferico_tx dut (
        .per_clock   (per_clock),
        .per_reset   (per_reset),
        .per_wr_en   (per_wr_en),
        .per_wr_data (per_wr_data),
        .per_full    (per_full),
        .per_count   (per_count),
        .per_ovf     (per_ovf),
        .per_send    (per_send),
        .per_ack     (per_ack),
        .per_dados   (per_dados)
    );

    always #5 per_clock = ~per_clock;

    task automatic tick();
        @(posedge per_clock);
        #1;
    endtask

    task automatic wait_send(output bit ok);
        ok = per_send;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = per_send;
        end
    endtask

    // CPU side: ack after dly cycles, then drop ack one cycle later.
    task automatic cpu_ack(input int dly);
        for (int i = 0; i < dly; i++) tick();
        per_ack = 1'b1;
        tick();
        per_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2 per_reset = 1'b0;
        #1;
        n_total++;
        if ({per_send, per_dados, per_count, per_full, per_ovf} !== 10'd0)
            $display("FAIL reset_state got=%b want=0",
                     {per_send, per_dados, per_count, per_full, per_ovf});
        else n_pass++;
        tick();
        tick();
        per_reset = 1'b1;
        tick();
        n_total++;
        if (per_send !== 1'b0) $display("FAIL reset_idle got=%b want=0", per_send);
        else n_pass++;
    endtask

    task automatic test_single();
        per_wr_en = 1'b1;
        per_wr_data = 4'hA;
        tick();
        per_wr_en = 1'b0;
        n_total++;
        if (per_send !== 1'b0 || per_count !== 3'd1)
            $display("FAIL single_push got=%b/%0d want=0/1", per_send, per_count);
        else n_pass++;
        tick();
        n_total++;
        if (per_send !== 1'b1 || per_dados !== 4'hA || per_count !== 3'd0)
            $display("FAIL single_send got=%b/%h/%0d want=1/a/0",
                     per_send, per_dados, per_count);
        else n_pass++;
        per_ack = 1'b1;
        tick();
        n_total++;
        if (per_send !== 1'b0) $display("FAIL single_fall got=%b want=0", per_send);
        else n_pass++;
        per_ack = 1'b0;
        tick();
        tick();
        n_total++;
        if (per_send !== 1'b0 || per_dados !== 4'hA)
            $display("FAIL single_hold got=%b/%h want=0/a", per_send, per_dados);
        else n_pass++;
    endtask

    task automatic test_burst();
        logic [3:0] exp_w [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        bit ok;
        per_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            per_wr_en = 1'b1;
            per_wr_data = exp_w[i];
            tick();
        end
        per_wr_en = 1'b0;
        n_total++;
        if (per_full !== 1'b1 || per_count !== 3'd4)
            $display("FAIL burst_full got=%b/%0d want=1/4", per_full, per_count);
        else n_pass++;
        per_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_send(ok);
            n_total++;
            if (!ok || per_dados !== exp_w[i])
                $display("FAIL burst_word%0d got=%h want=%h", i, per_dados, exp_w[i]);
            else n_pass++;
            cpu_ack(3);
        end
        n_total++;
        if (per_ovf !== 1'b0 || per_count !== 3'd0)
            $display("FAIL burst_end got=%b/%0d want=0/0", per_ovf, per_count);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [3:0] exp_w [4] = '{4'h6, 4'h7, 4'h8, 4'h9};
        bit ok;
        per_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            per_wr_en = 1'b1;
            per_wr_data = exp_w[i];
            tick();
        end
        n_total++;
        if (per_ovf !== 1'b0) $display("FAIL ovf_early got=%b want=0", per_ovf);
        else n_pass++;
        per_wr_data = 4'hF;
        tick();
        per_wr_en = 1'b0;
        n_total++;
        if (per_ovf !== 1'b1 || per_count !== 3'd4)
            $display("FAIL ovf_set got=%b/%0d want=1/4", per_ovf, per_count);
        else n_pass++;
        per_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_send(ok);
            n_total++;
            if (!ok || per_dados !== exp_w[i])
                $display("FAIL ovf_word%0d got=%h want=%h", i, per_dados, exp_w[i]);
            else n_pass++;
            cpu_ack(1);
        end
        tick();
        tick();
        n_total++;
        if (per_send !== 1'b0 || per_ovf !== 1'b1 || per_count !== 3'd0)
            $display("FAIL ovf_sticky got=%b/%b/%0d want=0/1/0",
                     per_send, per_ovf, per_count);
        else n_pass++;
    endtask

    task automatic test_stuck_ack();
        per_ack = 1'b1;
        per_wr_en = 1'b1;
        per_wr_data = 4'h5;
        tick();
        per_wr_en = 1'b0;
        tick();
        tick();
        tick();
        n_total++;
        if (per_send !== 1'b0 || per_count !== 3'd1)
            $display("FAIL stuck_hold got=%b/%0d want=0/1", per_send, per_count);
        else n_pass++;
        per_ack = 1'b0;
        tick();
        n_total++;
        if (per_send !== 1'b1 || per_dados !== 4'h5 || per_count !== 3'd0)
            $display("FAIL stuck_send got=%b/%h/%0d want=1/5/0",
                     per_send, per_dados, per_count);
        else n_pass++;
        cpu_ack(1);
    endtask

    task automatic test_push_pop();
        logic [3:0] exp_w [3] = '{4'hB, 4'hC, 4'hD};
        bit ok;
        per_ack = 1'b1;
        per_wr_en = 1'b1;
        per_wr_data = 4'hB;
        tick();
        per_wr_data = 4'hC;
        tick();
        per_wr_data = 4'hD;
        per_ack = 1'b0;
        tick();
        per_wr_en = 1'b0;
        n_total++;
        if (per_count !== 3'd2 || per_send !== 1'b1)
            $display("FAIL pp_count got=%0d/%b want=2/1", per_count, per_send);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            wait_send(ok);
            n_total++;
            if (!ok || per_dados !== exp_w[i])
                $display("FAIL pp_word%0d got=%h want=%h", i, per_dados, exp_w[i]);
            else n_pass++;
            cpu_ack(1);
        end
    endtask

    task automatic test_mid_reset();
        per_wr_en = 1'b1;
        per_wr_data = 4'h3;
        tick();
        per_wr_data = 4'h4;
        tick();
        per_wr_en = 1'b0;
        n_total++;
        if (per_send !== 1'b1 || per_count !== 3'd1)
            $display("FAIL mid_pre got=%b/%0d want=1/1", per_send, per_count);
        else n_pass++;
        #2 per_reset = 1'b0;
        #1;
        n_total++;
        if ({per_send, per_dados, per_count, per_ovf, per_full} !== 10'd0)
            $display("FAIL mid_reset got=%b want=0",
                     {per_send, per_dados, per_count, per_ovf, per_full});
        else n_pass++;
        tick();
        per_reset = 1'b1;
        tick();
        tick();
        tick();
        n_total++;
        if (per_send !== 1'b0 || per_count !== 3'd0)
            $display("FAIL mid_idle got=%b/%0d want=0/0", per_send, per_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_stuck_ack();
        test_push_pop();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
